// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-side front end.
// Datapath and address widths are fixed here and used by every file of the block.
package regfile_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_QUEUE,
        SRC_BYPASS
    } wb_src_t;

endpackage

// File: rtl/wb_queue.sv
// Long-latency result FIFO: circular buffer of wb_entry_t with wrapping pointers.
// Besides the head it exposes every slot plus a per-slot valid bit and the read
// pointer, so the forwarding logic can scan pending writes from oldest to newest.
// Push is ignored when full and pop is ignored when empty.
module wb_queue
    import regfile_wb_pkg::*;
#(
    parameter  int Q_DEPTH = 4,
    localparam int PTR_W   = $clog2(Q_DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  wb_entry_t          push_entry,
    input  logic               pop,
    output wb_entry_t          head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output wb_entry_t          entries [Q_DEPTH],
    output logic [Q_DEPTH-1:0] valid,
    output logic [PTR_W-1:0]   rd_ptr
);

    wb_entry_t          mem [Q_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [Q_DEPTH-1:0] vld;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(Q_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;
    assign valid   = vld;

    // Storage array: written on push only, contents are qualified by vld.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and slot-valid bits; push and pop may happen together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (pop_ok) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-side front end of the 32x32 register file. Arbitrates the single write
// port between the in-order ALU/MEM stream and buffered long-latency results,
// drives registered WE/AIn3/DIn, and answers two forwarding lookups.
// Handshake: a long-latency result transfers in any cycle where lu_valid and
// lu_ready are both high; the ALU stream has no handshake and is only held off
// by stall_alu, during which its inputs are ignored.
// Build option: RF_WB_R0_DISCARD_EN makes writes to r0 silent and never forwarded.
module regfile_write_arbiter
    import regfile_wb_pkg::*;
#(
    parameter  int Q_DEPTH      = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CNT_W        = $clog2(Q_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              stall_alu,
    output logic              WE,
    output logic [ADDR_W-1:0] AIn3,
    output logic [DATA_W-1:0] DIn,
    input  logic [ADDR_W-1:0] fwd_addr1,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    input  logic [ADDR_W-1:0] fwd_addr2,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CNT_W-1:0]  q_count
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int SC_W  = $clog2(STARVE_LIMIT) + 1;

`ifdef RF_WB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    wb_entry_t          q_head;
    wb_entry_t          q_entries [Q_DEPTH];
    logic [Q_DEPTH-1:0] q_valid;
    logic [PTR_W-1:0]   q_rd_ptr;
    logic               q_full;
    logic               q_empty;
    logic               q_push;
    logic               q_pop;
    logic               lu_fire;
    logic [SC_W-1:0]    starve_cnt;
    wb_src_t            sel;
    wb_entry_t          sel_entry;

    wb_queue #(.Q_DEPTH(Q_DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_entry ('{addr: lu_addr, data: lu_data}),
        .pop        (q_pop),
        .head       (q_head),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty),
        .entries    (q_entries),
        .valid      (q_valid),
        .rd_ptr     (q_rd_ptr)
    );

    // A same-cycle pop does not free a slot for the producer: ready is based on occupancy only.
    assign lu_ready  = rst_n & ~q_full;
    assign stall_alu = rst_n & (starve_cnt == SC_W'(STARVE_LIMIT - 1));
    assign lu_fire   = lu_valid & lu_ready;
    assign q_pop     = (sel == SRC_QUEUE);
    assign q_push    = lu_fire & (sel != SRC_BYPASS);

    // Write-port selection: forced drain, ALU, queue head, then direct bypass.
    always_comb begin
        sel       = SRC_NONE;
        sel_entry = '0;
        if (stall_alu) begin
            sel       = SRC_QUEUE;
            sel_entry = q_head;
        end else if (rst_n && alu_valid) begin
            sel       = SRC_ALU;
            sel_entry = '{addr: alu_addr, data: alu_data};
        end else if (rst_n && !q_empty) begin
            sel       = SRC_QUEUE;
            sel_entry = q_head;
        end else if (lu_fire) begin
            sel       = SRC_BYPASS;
            sel_entry = '{addr: lu_addr, data: lu_data};
        end
    end

    // Starvation counter: counts consecutive full-queue cycles with ALU traffic, clears on the forced drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (stall_alu) begin
            starve_cnt <= '0;
        end else if (q_full && alu_valid) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Output register: one-cycle latency; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WE   <= 1'b0;
            AIn3 <= '0;
            DIn  <= '0;
        end else if (sel != SRC_NONE) begin
            WE   <= ~(R0_DISCARD & (sel_entry.addr == '0));
            AIn3 <= sel_entry.addr;
            DIn  <= sel_entry.data;
        end else begin
            WE   <= 1'b0;
        end
    end

    // Returns {hit, data}: output register first, then queue newest to oldest.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic              hit;
        logic [DATA_W-1:0] d;
        logic [PTR_W-1:0]  slot;
        hit = 1'b0;
        d   = '0;
        if (rst_n && !(R0_DISCARD && a == '0)) begin
            // Scan oldest to newest so the newest match is the one kept.
            for (int i = 0; i < Q_DEPTH; i++) begin
                slot = q_rd_ptr + PTR_W'(i);
                if (q_valid[slot] && q_entries[slot].addr == a) begin
                    hit = 1'b1;
                    d   = q_entries[slot].data;
                end
            end
            if (WE && AIn3 == a) begin
                hit = 1'b1;
                d   = DIn;
            end
        end
        return {hit, d};
    endfunction

    // Forwarding lookups for the two decode read ports.
    always_comb begin
        {fwd_hit1, fwd_data1} = lookup(fwd_addr1);
        {fwd_hit2, fwd_data2} = lookup(fwd_addr2);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, ALU writes, ALU/LU conflict,
// queue fill and starvation drain, forwarding priority, bypass, r0 handling and
// reset in the middle of traffic.
module tb_regfile_write_arbiter;
    import regfile_wb_pkg::*;

    localparam int Q_DEPTH = 4;
    localparam int CNT_W   = $clog2(Q_DEPTH) + 1;

`ifdef RF_WB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              stall_alu;
    logic              WE;
    logic [ADDR_W-1:0] AIn3;
    logic [DATA_W-1:0] DIn;
    logic [ADDR_W-1:0] fwd_addr1;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic [ADDR_W-1:0] fwd_addr2;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;
    logic [CNT_W-1:0]  q_count;

    int n_cmp = 0;
    int n_err = 0;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter #(.Q_DEPTH(Q_DEPTH), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .stall_alu (stall_alu),
        .WE        (WE),
        .AIn3      (AIn3),
        .DIn       (DIn),
        .fwd_addr1 (fwd_addr1),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_addr2 (fwd_addr2),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .q_count   (q_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        lu_valid  = 1'b0;
        lu_addr   = '0;
        lu_data   = '0;
        fwd_addr1 = '0;
        fwd_addr2 = '0;

        // Reset held for two cycles
        tick();
        tick();
        chk("rst_we",       32'(WE),        32'd0);
        chk("rst_ain3",     32'(AIn3),      32'd0);
        chk("rst_din",      DIn,            32'd0);
        chk("rst_qcount",   32'(q_count),   32'd0);
        chk("rst_lu_ready", 32'(lu_ready),  32'd0);
        chk("rst_stall",    32'(stall_alu), 32'd0);
        chk("rst_hit1",     32'(fwd_hit1),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_lu_ready", 32'(lu_ready),  32'd1);
        chk("rel_stall",    32'(stall_alu), 32'd0);
        tick();
        chk("rel_no_write", 32'(WE), 32'd0);

        // ALU-only write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        chk("alu_we",   32'(WE),   32'd1);
        chk("alu_ain3", 32'(AIn3), 32'd5);
        chk("alu_din",  DIn,       32'hDEADBEEF);
        fwd_addr1 = 5'd5;
        #1;
        chk("alu_fwd_hit1",  32'(fwd_hit1), 32'd1);
        chk("alu_fwd_data1", fwd_data1,     32'hDEADBEEF);
        tick();
        chk("idle_we",        32'(WE),       32'd0);
        chk("idle_ain3_hold", 32'(AIn3),     32'd5);
        chk("idle_din_hold",  DIn,           32'hDEADBEEF);
        chk("idle_hit1",      32'(fwd_hit1), 32'd0);

        // ALU and LU in the same cycle
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1;
        lu_valid  = 1'b1; lu_addr  = 5'd7; lu_data  = 32'h2;
        #1;
        chk("conf_lu_ready", 32'(lu_ready), 32'd1);
        tick();
        alu_valid = 1'b0; lu_valid = 1'b0;
        chk("conf_we1",     32'(WE),      32'd1);
        chk("conf_ain3_1",  32'(AIn3),    32'd3);
        chk("conf_din1",    DIn,          32'h1);
        chk("conf_qcount1", 32'(q_count), 32'd1);
        fwd_addr2 = 5'd7;
        #1;
        chk("conf_fwd_hit2",  32'(fwd_hit2), 32'd1);
        chk("conf_fwd_data2", fwd_data2,     32'h2);
        tick();
        chk("conf_we2",     32'(WE),      32'd1);
        chk("conf_ain3_2",  32'(AIn3),    32'd7);
        chk("conf_din2",    DIn,          32'h2);
        chk("conf_qcount2", 32'(q_count), 32'd0);
        tick();
        chk("conf_we3", 32'(WE), 32'd0);

        // Fill the queue behind a continuous ALU stream
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA0;
        lu_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lu_addr = 5'(11 + i);
            lu_data = 32'(256 + i);
            tick();
            chk("fill_qcount", 32'(q_count), 32'(i + 1));
        end
        lu_valid = 1'b0;
        #1;
        chk("full_lu_ready", 32'(lu_ready), 32'd0);
        chk("full_qcount",   32'(q_count),  32'd4);
        // Full cycles 1..7: no stall yet
        for (int i = 0; i < 7; i++) begin
            chk("starve_pre", 32'(stall_alu), 32'd0);
            tick();
        end
        // Full cycle 8: forced drain
        chk("starve_stall",     32'(stall_alu), 32'd1);
        chk("starve_qcount",    32'(q_count),   32'd4);
        chk("starve_prev_ain3", 32'(AIn3),      32'd1);
        chk("starve_prev_din",  DIn,            32'hA0);
        tick();
        chk("stall_we",       32'(WE),        32'd1);
        chk("stall_ain3",     32'(AIn3),      32'd11);
        chk("stall_din",      DIn,            32'd256);
        chk("stall_qcount",   32'(q_count),   32'd3);
        chk("stall_cleared",  32'(stall_alu), 32'd0);
        chk("stall_lu_ready", 32'(lu_ready),  32'd1);
        alu_valid = 1'b0;
        tick();
        chk("drain_ain3_a", 32'(AIn3),    32'd12);
        chk("drain_qcnt_a", 32'(q_count), 32'd2);
        tick();
        chk("drain_ain3_b", 32'(AIn3),    32'd13);
        tick();
        chk("drain_ain3_c", 32'(AIn3),    32'd14);
        chk("drain_din_c",  DIn,          32'd259);
        chk("drain_qcnt_c", 32'(q_count), 32'd0);
        tick();
        chk("drain_we_idle", 32'(WE), 32'd0);

        // Forwarding: two queued writes to r9
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h55;
        lu_valid  = 1'b1; lu_addr  = 5'd9; lu_data  = 32'h11;
        tick();
        alu_addr = 5'd4; alu_data = 32'h66; lu_data = 32'h22;
        tick();
        alu_valid = 1'b0; lu_valid = 1'b0;
        fwd_addr1 = 5'd9; fwd_addr2 = 5'd10;
        #1;
        chk("fwdq_qcount", 32'(q_count),  32'd2);
        chk("fwdq_hit1",   32'(fwd_hit1), 32'd1);
        chk("fwdq_data1",  fwd_data1,     32'h22);
        chk("fwdq_hit2",   32'(fwd_hit2), 32'd0);
        chk("fwdq_data2",  fwd_data2,     32'h0);
        fwd_addr2 = 5'd4;
        #1;
        chk("fwdo_hit2",  32'(fwd_hit2), 32'd1);
        chk("fwdo_data2", fwd_data2,     32'h66);
        tick();
        // Older r9 now in the output register, newer r9 still queued
        chk("fwdp_ain3",  32'(AIn3),     32'd9);
        chk("fwdp_hit1",  32'(fwd_hit1), 32'd1);
        chk("fwdp_data1", fwd_data1,     32'h11);
        tick();
        chk("fwdl_data1",  fwd_data1,     32'h22);
        chk("fwdl_qcount", 32'(q_count),  32'd0);
        tick();
        chk("fwdm_hit1",  32'(fwd_hit1), 32'd0);
        chk("fwdm_data1", fwd_data1,     32'h0);

        // Bypass with an empty queue
        lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'h99;
        #1;
        chk("byp_lu_ready", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        chk("byp_we",     32'(WE),      32'd1);
        chk("byp_ain3",   32'(AIn3),    32'd8);
        chk("byp_din",    DIn,          32'h99);
        chk("byp_qcount", 32'(q_count), 32'd0);

        // r0 write through the bypass path
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hABC;
        tick();
        lu_valid = 1'b0;
        fwd_addr1 = 5'd0;
        #1;
        chk("r0_we",     32'(WE),       R0_DISCARD ? 32'd0 : 32'd1);
        chk("r0_qcount", 32'(q_count),  32'd0);
        chk("r0_hit1",   32'(fwd_hit1), R0_DISCARD ? 32'd0 : 32'd1);
        tick();

        // Reset with a write queued
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h5;
        lu_valid  = 1'b1; lu_addr  = 5'd21; lu_data  = 32'h6;
        tick();
        alu_valid = 1'b0; lu_valid = 1'b0;
        chk("mid_qcount", 32'(q_count), 32'd1);
        rst_n = 1'b0;
        fwd_addr1 = 5'd21;
        tick();
        chk("mid_rst_qcount",   32'(q_count),  32'd0);
        chk("mid_rst_we",       32'(WE),       32'd0);
        chk("mid_rst_lu_ready", 32'(lu_ready), 32'd0);
        chk("mid_rst_hit1",     32'(fwd_hit1), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_we",     32'(WE),       32'd0);
        chk("mid_rel_qcount", 32'(q_count),  32'd0);
        chk("mid_rel_hit1",   32'(fwd_hit1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
